inst_mem_loadable: RTL and testbench
====================================

// Module: inst_mem_loadable
// PURPOSE
//  Parametrised, byte-addressed instruction memory with a byte-serial boot-load port and a handshaked fetch port.
//  Fetch reads are registered; misaligned or out-of-range fetches are faulted.
//  Sits between the boot loader and the IF stage; program contents are streamed in at run time, not hard-coded.
// PARAMETERS
//  WORD_LEN    32    instruction/address width, bits; must be a multiple of CELL_W
//  CELL_W      8     memory cell (byte) width, bits
//  DEPTH       1024  memory size in cells; power of two, >= WORD_LEN/CELL_W
//  BIG_ENDIAN  1     1: cell at fetch_addr is the instruction MSB; 0: cell at fetch_addr is the LSB
// PORTS
//  clk          in   1         clock, rising edge
//  rst_n        in   1         asynchronous reset, active low
//  ld_start     in   1         pulse: restart load at cell 0
//  ld_valid     in   1         ld_data valid
//  ld_data      in   CELL_W    load byte
//  ld_last      in   1         qualifies the final load byte
//  ld_ready     out  1         load byte accepted this cycle when ld_valid=1
//  load_done    out  1         program loaded; fetch enabled
//  ld_err       out  1         sticky: load overflowed DEPTH
//  fetch_req    in   1         fetch request
//  fetch_addr   in   WORD_LEN  byte address of the instruction
//  fetch_gnt    out  1         request accepted this cycle (combinational)
//  fetch_valid  out  1         registered response valid
//  instruction  out  WORD_LEN  fetched instruction
//  fetch_fault  out  1         response is faulted; instruction=0
//  parity_err   out  1         parity mismatch on the response; see CONFIGURATION
// BEHAVIOUR
//  Reset: state=LOAD, wr_ptr=0, ld_err=0, load_done=0, fetch_valid=0, instruction=0, fetch_fault=0, parity_err=0.
//   The array is not reset.
//  FSM states: LOAD, READY.
//   LOAD:  ld_ready=1, fetch_gnt=0.
//          On ld_valid, write ld_data to mem[wr_ptr] and increment wr_ptr.
//          ld_valid&ld_last -> READY; load_done=1 from the next cycle.
//   READY: ld_ready=0, fetch_gnt=fetch_req&~ld_start.
//          ld_start -> LOAD with wr_ptr=0 and load_done=0; ld_err is kept.
//   ld_start in LOAD also resets wr_ptr to 0; the concurrent byte is dropped.
//  Overflow: wr_ptr saturates at DEPTH.
//   A byte arriving with wr_ptr==DEPTH is dropped and sets ld_err, which clears only on reset.
//   ld_last still moves the FSM to READY.
//  Fetch: 1-cycle latency.
//   A grant in cycle N gives fetch_valid=1 in cycle N+1 with instruction and fetch_fault.
//   fetch_valid=0 in any cycle after a non-granted cycle; instruction holds its last value.
//   Back-to-back grants are allowed, one response per cycle.
//  Assembly: NB=WORD_LEN/CELL_W cells at fetch_addr..fetch_addr+NB-1, ordered per BIG_ENDIAN.
//  Fault when fetch_addr % NB != 0 or fetch_addr > DEPTH-NB (all WORD_LEN bits compared; no wrap-around).
//   A faulted response has instruction=0 (NOP), fetch_fault=1 and no array read.
//  Reset mid-operation: an in-flight response is discarded, fetch_valid=0, and the FSM returns to LOAD.
//  Reading a cell never loaded returns an undefined value; that is not a fault.
// CONFIGURATION
//  IMEM_PARITY_EN defined:
//   Each cell stores one extra even-parity bit, computed on load.
//   On a non-faulted response, parity_err=1 if any of the NB cells mismatches.
//   The instruction is still delivered.
//  IMEM_PARITY_EN undefined:
//   No parity storage; parity_err is tied to 0.
// TESTING
//  1. Reset, stream 8 bytes 80 20 00 06 80 40 00 01 with ld_last on the 8th.
//     -> load_done=1; fetch 0 -> 32'h80200006, fetch 4 -> 32'h80400001, each one cycle after grant.
//  2. Fetch address 2 -> fetch_valid=1, fetch_fault=1, instruction=0.
//     Fetch address DEPTH-2 -> fault.
//     Fetch address DEPTH-4 -> no fault.
//  3. Fetch during LOAD -> fetch_gnt=0, no response.
//     ld_start together with fetch_req in READY -> fetch_gnt=0, load_done=0 next cycle.
//  4. Load DEPTH+2 bytes, the last with ld_last -> ld_err=1 and load_done=1; mem[0] holds the first byte.
//     Repeat after ld_start -> ld_err stays 1.
//  5. Assert rst_n=0 asynchronously mid-fetch -> outputs go to reset values immediately, state=LOAD.
//  6. With IMEM_PARITY_EN, force one stored bit flip, then fetch -> parity_err=1, instruction still returned.
//     Without the macro -> parity_err=0.
//  Run scenario 1 with BIG_ENDIAN=0 -> fetch 0 returns 32'h06002080.

Source files
------------

// File: rtl/inst_mem_loadable.sv
// Byte-addressed instruction memory: byte-serial boot-load port, registered handshaked fetch port.
// Optional per-cell even parity is enabled by defining IMEM_PARITY_EN.
module inst_mem_loadable #(
    parameter int WORD_LEN   = 32,
    parameter int CELL_W     = 8,
    parameter int DEPTH      = 1024,
    parameter int BIG_ENDIAN = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                ld_start,
    input  logic                ld_valid,
    input  logic [CELL_W-1:0]   ld_data,
    input  logic                ld_last,
    output logic                ld_ready,
    output logic                load_done,
    output logic                ld_err,
    input  logic                fetch_req,
    input  logic [WORD_LEN-1:0] fetch_addr,
    output logic                fetch_gnt,
    output logic                fetch_valid,
    output logic [WORD_LEN-1:0] instruction,
    output logic                fetch_fault,
    output logic                parity_err,
    output logic                dbg_state
);
    localparam int NB = WORD_LEN / CELL_W;
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    typedef enum logic {LOAD = 1'b0, READY = 1'b1} state_t;

    state_t                state, state_next;
    logic [PW-1:0]         wr_ptr;
    logic                  ptr_full;
    logic                  wr_en;
    logic                  addr_fault;
    logic [AW-1:0]         base;
    logic [WORD_LEN-1:0]   word_rd;
    logic [CELL_W-1:0]     mem [DEPTH];

    // Handshakes: a load byte is taken on any LOAD cycle with ld_valid (ld_ready=1 there),
    // a fetch is taken on any cycle with fetch_gnt=1; its response is valid exactly one cycle later.
    assign ptr_full  = (wr_ptr == PW'(DEPTH));
    assign load_done = (state == READY);
    assign dbg_state = (state == READY);
    assign base      = fetch_addr[AW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= LOAD;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        ld_ready   = 1'b0;
        fetch_gnt  = 1'b0;
        wr_en      = 1'b0;
        case (state)
            LOAD: begin
                ld_ready = 1'b1;
                // ld_start wins over a concurrent byte, which is dropped
                if (!ld_start && ld_valid) begin
                    wr_en = ~ptr_full;
                    if (ld_last) state_next = READY;
                end
            end
            READY: begin
                fetch_gnt = fetch_req & ~ld_start;
                if (ld_start) state_next = LOAD;
            end
            default: state_next = LOAD;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            ld_err <= 1'b0;
        end else if (ld_start) begin
            wr_ptr <= '0;
        end else if (state == LOAD && ld_valid) begin
            if (ptr_full) ld_err <= 1'b1;
            else          wr_ptr <= wr_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= ld_data;
    end

    // Full-width compare so high address bits can never alias into the array
    always_comb begin
        addr_fault = ((fetch_addr % WORD_LEN'(NB)) != '0) ||
                     (fetch_addr > WORD_LEN'(DEPTH - NB));
    end

    always_comb begin
        word_rd = '0;
        for (int k = 0; k < NB; k++) begin
            if (BIG_ENDIAN != 0) word_rd[(NB-1-k)*CELL_W +: CELL_W] = mem[base + AW'(k)];
            else                 word_rd[k*CELL_W +: CELL_W]        = mem[base + AW'(k)];
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_valid <= 1'b0;
            instruction <= '0;
            fetch_fault <= 1'b0;
        end else begin
            fetch_valid <= fetch_gnt;
            if (fetch_gnt) begin
                instruction <= addr_fault ? '0 : word_rd;
                fetch_fault <= addr_fault;
            end
        end
    end

`ifdef IMEM_PARITY_EN
    logic par_mem [DEPTH];
    logic par_bad;

    always_ff @(posedge clk) begin
        if (wr_en) par_mem[wr_ptr[AW-1:0]] <= ^ld_data;
    end

    always_comb begin
        par_bad = 1'b0;
        for (int k = 0; k < NB; k++) begin
            par_bad = par_bad | ((^mem[base + AW'(k)]) != par_mem[base + AW'(k)]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         parity_err <= 1'b0;
        else if (fetch_gnt) parity_err <= ~addr_fault & par_bad;
    end
`else
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_inst_mem_loadable.sv
// Directed bench for inst_mem_loadable: a big-endian and a little-endian instance share all inputs.
// Flipped-parity checks run only when IMEM_PARITY_EN is defined.
module tb_inst_mem_loadable;
    localparam int DEPTH = 64;
    localparam int W     = 32;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          ld_start = 1'b0, ld_valid = 1'b0, ld_last = 1'b0, fetch_req = 1'b0;
    logic [7:0]    ld_data = '0;
    logic [W-1:0]  fetch_addr = '0;

    logic          ld_ready, load_done, ld_err, fetch_gnt, fetch_valid, fetch_fault, parity_err, dbg_state;
    logic [W-1:0]  instruction;
    logic          le_ld_ready, le_load_done, le_ld_err, le_fetch_gnt, le_fetch_valid, le_fetch_fault;
    logic          le_parity_err, le_dbg_state;
    logic [W-1:0]  le_instruction;

    inst_mem_loadable #(.WORD_LEN(W), .CELL_W(8), .DEPTH(DEPTH), .BIG_ENDIAN(1)) dut (
        .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(ld_ready), .load_done(load_done), .ld_err(ld_err),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(fetch_gnt),
        .fetch_valid(fetch_valid), .instruction(instruction), .fetch_fault(fetch_fault),
        .parity_err(parity_err), .dbg_state(dbg_state)
    );

    inst_mem_loadable #(.WORD_LEN(W), .CELL_W(8), .DEPTH(DEPTH), .BIG_ENDIAN(0)) dut_le (
        .clk(clk), .rst_n(rst_n), .ld_start(ld_start), .ld_valid(ld_valid), .ld_data(ld_data),
        .ld_last(ld_last), .ld_ready(le_ld_ready), .load_done(le_load_done), .ld_err(le_ld_err),
        .fetch_req(fetch_req), .fetch_addr(fetch_addr), .fetch_gnt(le_fetch_gnt),
        .fetch_valid(le_fetch_valid), .instruction(le_instruction), .fetch_fault(le_fetch_fault),
        .parity_err(le_parity_err), .dbg_state(le_dbg_state)
    );

    // clock / reset
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    logic [W-1:0] exp_q[$];

    typedef struct {
        logic [W-1:0] addr;
        logic         fault;
        logic         chk;
        logic [W-1:0] be;
        logic [W-1:0] le;
    } vec_t;

    vec_t tab1[8];
    vec_t tab2[3];

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] pat(input int i);
        return 8'(i * 3 + 1);
    endfunction

    function automatic logic [W-1:0] be_word(input int a);
        return {pat(a), pat(a + 1), pat(a + 2), pat(a + 3)};
    endfunction

    function automatic logic [W-1:0] le_word(input int a);
        return {pat(a + 3), pat(a + 2), pat(a + 1), pat(a)};
    endfunction

    // driver tasks
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic last);
        ld_valid = 1'b1;
        ld_data  = b;
        ld_last  = last;
        tick();
        ld_valid = 1'b0;
        ld_last  = 1'b0;
    endtask

    task automatic fetch_one(input logic [W-1:0] addr, output logic gnt);
        fetch_req  = 1'b1;
        fetch_addr = addr;
        #1;
        gnt = fetch_gnt;
        tick();
        fetch_req = 1'b0;
    endtask

    task automatic run_vec(input vec_t v, input string tag);
        logic g;
        fetch_one(v.addr, g);
        chk({tag, "_gnt"}, W'(g), 1);
        chk({tag, "_valid"}, W'(fetch_valid), 1);
        chk({tag, "_fault"}, W'(fetch_fault), W'(v.fault));
        chk({tag, "_le_fault"}, W'(le_fetch_fault), W'(v.fault));
        chk({tag, "_parity"}, W'(parity_err), 0);
        if (v.chk) begin
            chk({tag, "_instr_be"}, instruction, v.be);
            chk({tag, "_instr_le"}, le_instruction, v.le);
        end
    endtask

    logic [7:0] prog[8];
    logic       g;

    initial begin
        prog = '{8'h80, 8'h20, 8'h00, 8'h06, 8'h80, 8'h40, 8'h00, 8'h01};
        tab1[0] = '{32'd0,        1'b0, 1'b1, 32'h80200006, 32'h06002080};
        tab1[1] = '{32'd4,        1'b0, 1'b1, 32'h80400001, 32'h01004080};
        tab1[2] = '{32'd2,        1'b1, 1'b1, 32'h0,        32'h0};
        tab1[3] = '{32'd1,        1'b1, 1'b1, 32'h0,        32'h0};
        tab1[4] = '{W'(DEPTH-2),  1'b1, 1'b1, 32'h0,        32'h0};
        tab1[5] = '{W'(DEPTH-4),  1'b0, 1'b0, 32'h0,        32'h0};
        tab1[6] = '{W'(DEPTH),    1'b1, 1'b1, 32'h0,        32'h0};
        tab1[7] = '{32'h80000000, 1'b1, 1'b1, 32'h0,        32'h0};
        tab2[0] = '{32'd0,       1'b0, 1'b1, be_word(0),       le_word(0)};
        tab2[1] = '{32'd4,       1'b0, 1'b1, be_word(4),       le_word(4)};
        tab2[2] = '{W'(DEPTH-4), 1'b0, 1'b1, be_word(DEPTH-4), le_word(DEPTH-4)};

        // reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_load_done", W'(load_done), 0);
        chk("rst_ld_ready", W'(ld_ready), 1);
        chk("rst_ld_err", W'(ld_err), 0);
        chk("rst_valid", W'(fetch_valid), 0);
        chk("rst_instr", instruction, 0);
        chk("rst_fault", W'(fetch_fault), 0);
        chk("rst_parity", W'(parity_err), 0);
        chk("rst_state", W'(dbg_state), 0);
        rst_n = 1'b1;
        tick();

        // load the 8-byte program
        for (int i = 0; i < 8; i++) send_byte(prog[i], i == 7);
        chk("s1_load_done", W'(load_done), 1);
        chk("s1_ld_ready", W'(ld_ready), 0);
        chk("s1_ld_err", W'(ld_err), 0);
        chk("s1_le_load_done", W'(le_load_done), 1);

        for (int i = 0; i < 8; i++) run_vec(tab1[i], $sformatf("t1_%0d", i));

        // back-to-back grants, one response per cycle
        exp_q.push_back(32'h80200006);
        exp_q.push_back(32'h80400001);
        fetch_req  = 1'b1;
        fetch_addr = 32'd0;
        tick();
        chk("b2b_valid0", W'(fetch_valid), 1);
        chk("b2b_instr0", instruction, exp_q.pop_front());
        fetch_addr = 32'd4;
        tick();
        chk("b2b_valid1", W'(fetch_valid), 1);
        chk("b2b_instr1", instruction, exp_q.pop_front());
        fetch_req = 1'b0;
        tick();
        chk("b2b_idle_valid", W'(fetch_valid), 0);
        chk("b2b_hold_instr", instruction, 32'h80400001);

        // ld_start with fetch_req in READY
        fetch_req  = 1'b1;
        fetch_addr = 32'd0;
        ld_start   = 1'b1;
        #1;
        chk("s3_start_gnt", W'(fetch_gnt), 0);
        tick();
        ld_start  = 1'b0;
        fetch_req = 1'b0;
        chk("s3_load_done", W'(load_done), 0);
        chk("s3_valid", W'(fetch_valid), 0);
        chk("s3_ld_ready", W'(ld_ready), 1);
        chk("s3_state", W'(dbg_state), 0);

        // fetch during LOAD
        fetch_req = 1'b1;
        #1;
        chk("s3_load_gnt", W'(fetch_gnt), 0);
        tick();
        fetch_req = 1'b0;
        chk("s3_load_valid", W'(fetch_valid), 0);

        // ld_start in LOAD drops the concurrent byte, then overflow load
        ld_start = 1'b1;
        ld_valid = 1'b1;
        ld_data  = 8'hee;
        tick();
        ld_start = 1'b0;
        ld_valid = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            send_byte(pat(i), i == DEPTH + 1);
            if (i == DEPTH - 1) chk("s4_no_err_yet", W'(ld_err), 0);
        end
        chk("s4_ld_err", W'(ld_err), 1);
        chk("s4_load_done", W'(load_done), 1);

        for (int i = 0; i < 3; i++) run_vec(tab2[i], $sformatf("t2_%0d", i));

        // ld_err survives a new load
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
        chk("s4r_load_done0", W'(load_done), 0);
        chk("s4r_ld_err0", W'(ld_err), 1);
        for (int i = 0; i < 3; i++) send_byte(pat(i), i == 2);
        chk("s4r_ld_err", W'(ld_err), 1);
        chk("s4r_load_done", W'(load_done), 1);

`ifdef IMEM_PARITY_EN
        dut.par_mem[5] = ~dut.par_mem[5];
        fetch_one(32'd4, g);
        chk("s6_gnt", W'(g), 1);
        chk("s6_parity_err", W'(parity_err), 1);
        chk("s6_instr", instruction, be_word(4));
        dut.par_mem[5] = ~dut.par_mem[5];
`else
        fetch_one(32'd4, g);
        chk("s6_gnt", W'(g), 1);
        chk("s6_parity_err", W'(parity_err), 0);
        chk("s6_instr", instruction, be_word(4));
`endif

        // asynchronous reset mid-fetch
        fetch_req  = 1'b1;
        fetch_addr = 32'd0;
        tick();
        chk("s5_valid_before", W'(fetch_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("s5_valid", W'(fetch_valid), 0);
        chk("s5_instr", instruction, 0);
        chk("s5_fault", W'(fetch_fault), 0);
        chk("s5_load_done", W'(load_done), 0);
        chk("s5_ld_err", W'(ld_err), 0);
        chk("s5_state", W'(dbg_state), 0);
        chk("s5_ld_ready", W'(ld_ready), 1);
        fetch_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        chk("s5_post_valid", W'(fetch_valid), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
